fpi2c_arbiter: RTL
==================

Name: fpi2c_arbiter

Overview:
- Shares one front-panel i2cmaster command/status engine between NREQ requesters, e.g. ARM register path (req 0) and autonomous panel scanner (req 1).
- Round-robin arbitration; latches the winner's 64-bit command and issues it as a one-cycle write strobe.
- Tracks the engine's busy flag to completion, enforces a watchdog timeout (clears a hung engine), and returns captured status plus a done pulse to the winner only.

Parameters:
NREQ, 2, number of requesters (2..8)
TMOUT, 1000000, watchdog limit in CLOCK cycles from issue to completion
CNTW, 20, counter width; must satisfy 2**CNTW > TMOUT

Ports:
CLOCK  in  1  system clock
RESET  in  1  synchronous active-high reset
req  in  NREQ  per-requester request level
cmd  in  64*NREQ  per-requester command; requester i uses bits [64*i+63:64*i]
grant  out  NREQ  one-hot, high from latch through DONE for selected requester
done  out  NREQ  one-cycle completion pulse to selected requester
rsp_status  out  64  engine status captured at completion; valid from done pulse until next done
rsp_tmo  out  1  1 = last completion was a watchdog abort; same validity as rsp_status
busy  out  1  high whenever state != IDLE
m_wrcmd  out  1  one-cycle command write strobe to engine
m_command  out  64  latched command presented to engine
m_clear  out  1  one-cycle engine clear (abort)
m_busy  in  1  engine busy flag (1 while command executing)
m_status  in  64  engine status word

Behaviour:
- States: IDLE, ISSUE, START, RUN, ABORT, DONE.
- Reset values: state IDLE; grant 0; done 0; m_wrcmd 0; m_clear 0; m_command 0; rsp_status 0; rsp_tmo 0; busy 0; counter 0; last winner NREQ-1 (req 0 wins first).
- Reset mid-operation: immediate return to IDLE with reset values. No m_clear pulse; engine is reset by its own RESET.
- IDLE:
  - If any req bit set, select the first set bit scanning last+1, last+2, ... modulo NREQ.
  - Latch sel, m_command <= cmd[sel], grant[sel] <= 1, counter <= 0.
  - Next state ISSUE. Arbitration decision takes 1 cycle.
- ISSUE: m_wrcmd = 1 for exactly this cycle -> START.
  - cmd changes after the latch cycle are ignored.
- START (waiting for busy to rise):
  - m_busy = 1 -> RUN.
  - counter reaches TMOUT -> ABORT.
  - Otherwise counter increments.
- RUN:
  - m_busy = 0 -> DONE with rsp_status <= m_status, rsp_tmo <= 0.
  - counter reaches TMOUT -> ABORT.
  - Otherwise counter increments.
- ABORT: m_clear = 1 for one cycle; rsp_status <= m_status; rsp_tmo <= 1 -> DONE.
- DONE: done[sel] = 1 for one cycle; last <= sel; next cycle grant <= 0, state IDLE.
  - A requester that keeps req high re-arbitrates, but every other pending requester is served first.
- Counter saturates and never wraps. Timeout check has priority over the busy check in the same cycle.
- req dropped mid-transaction: ignored; transaction completes and done still pulses.
- m_command holds its value after completion until the next latch.
- Minimum transaction: IDLE->ISSUE->START->RUN->DONE, so done arrives no earlier than 4 cycles after latch.
- Only one engine command is ever outstanding.

Test Plan:
- Single requester: req[0]=1, cmd0=64'h0123_4567_89AB_CDEF, engine model busy 3 cycles -> one m_wrcmd with that value, grant=2'b01, done[0] pulse, rsp_status = model status, rsp_tmo=0.
- Both requesters held continuously -> grants alternate 0,1,0,1. After reset the first grant is req 0. done never pulses on the non-granted line.
- Command stability: change cmd0 to all-ones the cycle after grant -> m_command stays 64'h0123_4567_89AB_CDEF through done.
- Watchdog: TMOUT=50, model holds m_busy=1 forever -> m_clear pulses once, done pulses, rsp_tmo=1. Next request proceeds normally with rsp_tmo=0.
- Busy never rises: model ignores m_wrcmd -> ABORT after TMOUT cycles, m_clear pulse, rsp_tmo=1.
- Reset mid-RUN: assert RESET one cycle -> next cycle grant=0, busy=0, no done, no m_clear. Next arbitration starts at req 0.

Source files
------------

// File: rtl/fpi2c_arbiter.sv
// Round-robin arbiter sharing one front-panel i2cmaster command/status engine
// between NREQ requesters, with a watchdog that clears a hung engine.
module fpi2c_arbiter #(
    parameter int NREQ  = 2,
    parameter int TMOUT = 1000000,
    parameter int CNTW  = 20
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic [NREQ-1:0]      req,
    input  logic [64*NREQ-1:0]   cmd,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic [63:0]          rsp_status,
    output logic                 rsp_tmo,
    output logic                 busy,
    output logic                 m_wrcmd,
    output logic [63:0]          m_command,
    output logic                 m_clear,
    input  logic                 m_busy,
    input  logic [63:0]          m_status
);

    localparam int              SELW      = $clog2(NREQ);
    localparam logic [CNTW-1:0] CNT_LIMIT = CNTW'(TMOUT);

    typedef enum logic [2:0] {IDLE, ISSUE, START, RUN, ABORT, DONE} state_t;

    state_t            state_q, state_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [SELW-1:0]   last_q, last_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [63:0]       m_command_q, m_command_d;
    logic [63:0]       rsp_status_q, rsp_status_d;
    logic              rsp_tmo_q, rsp_tmo_d;

    logic              any_req;
    logic [SELW-1:0]   win_idx;
    logic [63:0]       win_cmd;
    logic [CNTW-1:0]   cnt_inc;

    function automatic int rr_index(input int last, input int k);
        return (last + k) % NREQ;
    endfunction

    // First pending requester after the previous winner, wrapping around.
    always_comb begin
        any_req = 1'b0;
        win_idx = '0;
        win_cmd = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!any_req && req[rr_index(int'(last_q), k)]) begin
                any_req = 1'b1;
                win_idx = SELW'(rr_index(int'(last_q), k));
                win_cmd = cmd[64*rr_index(int'(last_q), k) +: 64];
            end
        end
    end

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNTW'(1);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        sel_d        = sel_q;
        last_d       = last_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        m_command_d  = m_command_q;
        rsp_status_d = rsp_status_q;
        rsp_tmo_d    = rsp_tmo_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    sel_d       = win_idx;
                    m_command_d = win_cmd;
                    grant_d     = NREQ'(1) << win_idx;
                    cnt_d       = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: state_d = START;
            START: begin
                if (cnt_q == CNT_LIMIT)  state_d = ABORT;
                else if (m_busy)         state_d = RUN;
                else                     cnt_d   = cnt_inc;
            end
            RUN: begin
                if (cnt_q == CNT_LIMIT) begin
                    state_d = ABORT;
                end else if (!m_busy) begin
                    rsp_status_d = m_status;
                    rsp_tmo_d    = 1'b0;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ABORT: begin
                rsp_status_d = m_status;
                rsp_tmo_d    = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                last_d  = sel_q;
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            last_q       <= SELW'(NREQ - 1);
            grant_q      <= '0;
            cnt_q        <= '0;
            m_command_q  <= '0;
            rsp_status_q <= '0;
            rsp_tmo_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_q       <= last_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            m_command_q  <= m_command_d;
            rsp_status_q <= rsp_status_d;
            rsp_tmo_q    <= rsp_tmo_d;
        end
    end

    assign grant      = grant_q;
    assign done       = (state_q == DONE) ? grant_q : '0;
    assign m_wrcmd    = (state_q == ISSUE);
    assign m_clear    = (state_q == ABORT);
    assign busy       = (state_q != IDLE);
    assign m_command  = m_command_q;
    assign rsp_status = rsp_status_q;
    assign rsp_tmo    = rsp_tmo_q;

endmodule
